// File: rtl/alu_ctrl_mc.sv
// -----------------------------------------------------------------------------
// alu_ctrl_mc
// Registered ALU control decoder with MUL/DIV busy sequencing.
// Decodes alu_op_in and the funct field of instr_in into a 4-bit ALU control
// code, issues it one cycle after acceptance, and holds the block busy for
// MUL_LAT / DIV_LAT cycles when a multi-cycle operation is issued.
//
// State table:
//   IDLE | accepting requests, ready_out=1
//   BUSY | MUL/DIV in progress, cnt_q counts down to the last busy cycle
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   instr_in       in   instruction word (only [FUNCT_W-1:0] used)
//   alu_op_in      in   ALU op class from main control
//   valid_in       in   decode request, taken only while ready_out=1
//   ready_out      out  block can accept a request (state is IDLE)
//   alu_ctrl_out   out  registered ALU control code
//   ctrl_valid_out out  one-cycle pulse when a new code is issued
//   busy_out       out  multi-cycle operation in progress
//   done_out       out  one-cycle pulse on the last busy cycle
//   illegal_out    out  one-cycle pulse with ctrl_valid_out on unknown funct
// -----------------------------------------------------------------------------
module alu_ctrl_mc #(
    parameter int INSTR_W = 32,
    parameter int FUNCT_W = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [1:0]         alu_op_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [3:0]         alu_ctrl_out,
    output logic               ctrl_valid_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               illegal_out
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT);

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_MUL  = 4'b0010;
    localparam logic [3:0] C_DIV  = 4'b0011;
    localparam logic [3:0] C_AND  = 4'b0100;
    localparam logic [3:0] C_OR   = 4'b0101;
    localparam logic [3:0] C_NOR  = 4'b0110;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_SRL  = 4'b1000;
    localparam logic [3:0] C_SLT  = 4'b1001;
    localparam logic [3:0] C_XOR  = 4'b1010;
    localparam logic [3:0] C_SLTI = 4'b1011;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic               cv_q, cv_d;
    logic               done_q, done_d;
    logic               ill_q, ill_d;

    logic [FUNCT_W-1:0] funct;
    logic [3:0]         dec_code;
    logic               dec_illegal;

    assign funct = instr_in[FUNCT_W-1:0];

    // Upper instruction bits are intentionally ignored.
    logic unused_instr_hi;
    assign unused_instr_hi = ^instr_in[INSTR_W-1:FUNCT_W];

    // Combinational decode of the incoming request.
    always_comb begin
        dec_code    = C_ADD;
        dec_illegal = 1'b0;
        unique case (alu_op_in)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b11: dec_code = C_NOP;
            2'b10: begin
                case (funct)
                    FUNCT_W'(6'b100000): dec_code = C_ADD;
                    FUNCT_W'(6'b100010): dec_code = C_SUB;
                    FUNCT_W'(6'b000010): dec_code = C_MUL;
                    FUNCT_W'(6'b011010): dec_code = C_DIV;
                    FUNCT_W'(6'b100100): dec_code = C_AND;
                    FUNCT_W'(6'b100101): dec_code = C_OR;
                    FUNCT_W'(6'b100111): dec_code = C_NOR;
                    FUNCT_W'(6'b000000): dec_code = C_NOP;
                    FUNCT_W'(6'b000011): dec_code = C_SRL;
                    FUNCT_W'(6'b101010): dec_code = C_SLT;
                    FUNCT_W'(6'b100110): dec_code = C_XOR;
                    FUNCT_W'(6'b001010): dec_code = C_SLTI;
                    FUNCT_W'(6'b001101): dec_code = C_OR;
                    FUNCT_W'(6'b001000): dec_code = C_ADD;
                    FUNCT_W'(6'b001100): dec_code = C_AND;
                    default: begin
                        dec_code    = C_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_code = C_ADD;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        cv_d    = 1'b0;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    ctrl_d = dec_code;
                    cv_d   = 1'b1;
                    ill_d  = dec_illegal;
                    if (dec_code == C_MUL) begin
                        state_d = BUSY;
                        cnt_d   = MUL_LOAD;
                    end else if (dec_code == C_DIV) begin
                        state_d = BUSY;
                        cnt_d   = DIV_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // done is registered, so raise it one edge early: it is then
                // visible in the cycle where cnt_q reaches zero.
                if (cnt_q == CNT_W'(1)) begin
                    done_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= 4'b0000;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign alu_ctrl_out   = ctrl_q;
    assign ctrl_valid_out = cv_q;
    assign done_out       = done_q;
    assign illegal_out    = ill_q;
    assign busy_out       = (state_q == BUSY);
    assign ready_out      = (state_q == IDLE);

endmodule
